// File: rtl/pixel_pkg.sv
// ---------------------------------------------------------------------------
// pixel_pkg
//   Shared definitions for the frame-buffer read sequencer:
//   - frame geometry and datapath widths
//   - controller FSM state encoding
//   - read-owner tag used to route buffer returns
//   - saturating increment used by the overrun counter
// ---------------------------------------------------------------------------
package pixel_pkg;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 8;
  localparam int OVR_W      = 8;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Who issued the read whose data arrives next cycle.
  typedef enum logic {
    OWN_STREAM = 1'b0,
    OWN_DBG    = 1'b1
  } owner_t;

  function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
    return (v == '1) ? v : v + OVR_W'(1);
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// ---------------------------------------------------------------------------
// pixel_skid_fifo
//   Two-entry FIFO of {pixel index, pixel data} between the frame-buffer
//   return path and the stream output. The head entry is presented
//   combinationally and stays stable until it is popped.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        drop all entries (wins over a simultaneous push)
//   push         write push_index/push_data
//   pop          retire the head entry (ignored when empty)
//   empty, full  occupancy flags
//   count        occupancy 0..2
//   head_index   index of the head entry
//   head_data    data of the head entry
// ---------------------------------------------------------------------------
module pixel_skid_fifo
  import pixel_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_index,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              empty,
  output logic              full,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_index,
  output logic [DATA_W-1:0] head_data
);

  logic [ADDR_W-1:0] idx_mem [2];
  logic [DATA_W-1:0] dat_mem [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign empty      = (count_q == 2'd0);
  assign full       = (count_q == 2'd2);
  assign count      = count_q;
  assign do_pop     = pop && !empty;
  // A full FIFO can still accept a push when the head leaves the same edge.
  assign do_push    = push && (!full || do_pop);
  assign head_index = idx_mem[rd_ptr_q];
  assign head_data  = dat_mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= !wr_ptr_q;
      if (do_pop)  rd_ptr_q <= !rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the controller qualifies it with occupancy.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      idx_mem[wr_ptr_q] <= push_index;
      dat_mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pixel_stream_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_stream_ctrl
//   After each captured frame, reads pixels 0..NUM_PIXELS-1 out of the frame
//   buffer and streams them to the inference engine over valid/ready. The
//   same read port is shared with a low-priority debug readback requester.
//
// Ports
//   pix_clk, rst_n    clock, asynchronous active-low reset
//   frame_start       new capture begins; aborts an active stream
//   frame_done        1-cycle pulse, frame fully captured; starts a stream
//   buf_rd_en/addr    frame buffer read request
//   buf_rd_data       frame buffer data, valid one cycle after buf_rd_en
//   pix_valid/ready   stream handshake
//   pix_data/index    current beat payload and its pixel address
//   pix_last          beat carries pixel NUM_PIXELS-1
//   dbg_req/addr      debug read request (held until dbg_gnt)
//   dbg_gnt           debug read issued this cycle
//   dbg_valid/data    debug return, one cycle after dbg_gnt
//   busy              streaming or draining
//   stream_done       pulse in the cycle the drained stream returns to idle
//   stream_abort      pulse in the cycle after an abort
//   overrun_cnt       saturating count of frame_done pulses seen while busy
// ---------------------------------------------------------------------------
module pixel_stream_ctrl
  import pixel_pkg::*;
(
  input  logic              pix_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [ADDR_W-1:0] pix_index,
  output logic              pix_last,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_valid,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              stream_done,
  output logic              stream_abort,
  output logic [OVR_W-1:0]  overrun_cnt
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] rp_q;
  logic [ADDR_W-1:0] rp_d;

  logic              rd_vld_p1;
  owner_t            rd_owner_p1;
  logic [ADDR_W-1:0] rd_idx_p1;

  logic [OVR_W-1:0]  overrun_q;
  logic              abort_q;

  logic              busy_w;
  logic              abort;
  logic              beat;
  logic              stream_ret;
  logic              two_committed;
  logic              credit_ok;
  logic              stream_issue;
  logic              done_w;

  logic              fifo_empty;
  logic              fifo_full;
  logic [1:0]        fifo_count;
  logic [ADDR_W-1:0] head_index;
  logic [DATA_W-1:0] head_data;

  assign busy_w     = (state_q != ST_IDLE);
  assign abort      = frame_start && busy_w;
  assign beat       = pix_valid && pix_ready;
  assign stream_ret = rd_vld_p1 && (rd_owner_p1 == OWN_STREAM);

  // Stream reads are limited to two outstanding beyond the consumer: FIFO
  // entries plus the read returning now. A beat leaving this cycle frees a
  // slot early, which keeps the stream at one beat per cycle.
  assign two_committed = fifo_full || ((fifo_count != 2'd0) && stream_ret);
  assign credit_ok     = !two_committed || beat;

  always_comb begin
    state_d      = state_q;
    rp_d         = rp_q;
    stream_issue = 1'b0;
    done_w       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_done && !frame_start) begin
          state_d = ST_STREAM;
          rp_d    = '0;
        end
      end
      ST_STREAM: begin
        // No stream read is launched on the abort edge, so nothing
        // stale can land in the FIFO afterwards.
        if (frame_start) begin
          state_d = ST_IDLE;
        end else if (credit_ok) begin
          stream_issue = 1'b1;
          if (rp_q == LAST_IDX) state_d = ST_DRAIN;
          else                  rp_d    = rp_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (frame_start) begin
          state_d = ST_IDLE;
        end else if (fifo_empty && !stream_ret) begin
          state_d = ST_IDLE;
          done_w  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fixed priority arbiter: debug only gets cycles the stream leaves idle.
  assign dbg_gnt     = dbg_req && !stream_issue;
  assign buf_rd_en   = stream_issue || dbg_gnt;
  assign buf_rd_addr = stream_issue ? rp_q : (dbg_gnt ? dbg_addr : '0);

  // Stage p0 -> p1: read issued, owner/index travel with the return.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rp_q        <= '0;
      rd_vld_p1   <= 1'b0;
      rd_owner_p1 <= OWN_STREAM;
      overrun_q   <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rp_q        <= rp_d;
      rd_vld_p1   <= buf_rd_en;
      rd_owner_p1 <= dbg_gnt ? OWN_DBG : OWN_STREAM;
      abort_q     <= abort;
      if (frame_done && busy_w && !frame_start) overrun_q <= sat_inc(overrun_q);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (stream_issue) rd_idx_p1 <= rp_q;
  end

  // Stage p1 -> FIFO: stream returns are queued; debug returns bypass.
  pixel_skid_fifo u_fifo (
    .clk        (pix_clk),
    .rst_n      (rst_n),
    .flush      (abort),
    .push       (stream_ret),
    .push_index (rd_idx_p1),
    .push_data  (buf_rd_data),
    .pop        (beat),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count),
    .head_index (head_index),
    .head_data  (head_data)
  );

  assign pix_valid    = !fifo_empty;
  assign pix_data     = pix_valid ? head_data : '0;
  assign pix_index    = pix_valid ? head_index : '0;
  assign pix_last     = pix_valid && (head_index == LAST_IDX);

  assign dbg_valid    = rd_vld_p1 && (rd_owner_p1 == OWN_DBG);
  assign dbg_data     = dbg_valid ? buf_rd_data : '0;

  assign busy         = busy_w;
  assign stream_done  = done_w;
  assign stream_abort = abort_q;
  assign overrun_cnt  = overrun_q;

endmodule
